dbus_mem_responder: RTL

- Responder end of the data-bus protocol driven by the commit stage: accepts dbus_req_t, returns dbus_resp_t (addr_ok / data_ok / data).
- Backs the bus with a synchronous single-port SRAM of fixed read latency; also acknowledges cache-op requests with a multi-cycle busy sequence.
- Sits between the commit stage's dmem_req/dmem_resp and on-chip data SRAM, for simulation and cache-less builds.

---
 rtl/dbus_mem_responder_pkg.sv | 48 ++++
 rtl/dbus_lat_pipe.sv | 40 ++++
 rtl/dbus_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// Shared types for the data-bus responder.
//   cache_op_t        : cache-op sub-request (req, funct)
//   dbus_req_t        : requester -> responder bundle
//   dbus_resp_t       : responder -> requester bundle (addr_ok, data_ok, data)
//   dbus_rsp_state_t  : responder FSM states
// Also holds the saturating-increment helpers used by the optional
// performance counters (DBUS_RESP_PERF_EN).
package dbus_mem_responder_pkg;

  typedef struct packed {
    logic       req;
    logic [4:0] funct;
  } cache_op_t;

  typedef struct packed {
    logic        req;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  write_en;
    logic [1:0]  size;
    cache_op_t   cache_op;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    RSP_IDLE       = 2'd0,
    RSP_CACHE_BUSY = 2'd1,
    RSP_CACHE_DONE = 2'd2
  } dbus_rsp_state_t;

  // Outstanding counter width; DEPTH is at most 4.
  localparam int unsigned OUTSTANDING_W = 3;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dbus_lat_pipe.sv
// MEM_LATENCY-deep shift register tracking in-flight SRAM accesses.
//   clk, reset   : clock, synchronous active-high reset (empties the pipe)
//   in_valid     : an access is launched this cycle
//   in_is_write  : that access is a write
//   out_valid    : an access leaves the pipe this cycle (response strobe)
//   out_is_write : the leaving access was a write
module dbus_lat_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_is_write,
  output logic out_valid,
  output logic out_is_write
);

  localparam int unsigned LAST = LATENCY - 1;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      wr_q    <= '0;
    end else begin
      valid_q[0] <= in_valid;
      wr_q[0]    <= in_valid & in_is_write;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        wr_q[i]    <= wr_q[i-1];
      end
    end
  end

  assign out_valid    = valid_q[LAST];
  assign out_is_write = wr_q[LAST];

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus responder backed by a synchronous single-port SRAM.
// Accepts dbus_req_t from the commit stage, launches the SRAM access on the
// accept cycle and returns data_ok MEM_LATENCY cycles later, in order.
// Cache-op requests are acknowledged after CACHEOP_CYCLES busy cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   dmem_req   : request bundle (dbus_req_t)
//   dmem_resp  : addr_ok / data_ok / data (dbus_resp_t)
//   sram_en    : SRAM access enable
//   sram_we    : SRAM byte write strobes
//   sram_addr  : SRAM word address (dmem_req.addr[SRAM_AW+1:2])
//   sram_wd    : SRAM write data
//   sram_rd    : SRAM read data, valid MEM_LATENCY cycles after sram_en
// Optional: define DBUS_RESP_PERF_EN to add perf_req_cnt, perf_stall_cnt
// and perf_cacheop_cnt saturating counters.
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned SRAM_AW        = 14,
  parameter int unsigned CACHEOP_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  dbus_req_t          dmem_req,
  output dbus_resp_t         dmem_resp,
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wd,
  input  logic [31:0]        sram_rd
`ifdef DBUS_RESP_PERF_EN
  ,
  output logic [31:0]        perf_req_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [15:0]        perf_cacheop_cnt
`endif
);

  localparam logic [OUTSTANDING_W-1:0] DEPTH_L = OUTSTANDING_W'(DEPTH);
  localparam int unsigned COP_W = (CACHEOP_CYCLES > 1) ? $clog2(CACHEOP_CYCLES) : 1;
  localparam logic [COP_W-1:0] COP_LOAD = COP_W'(CACHEOP_CYCLES - 1);

  dbus_rsp_state_t           state;
  logic [COP_W-1:0]          cop_cnt;
  logic [OUTSTANDING_W-1:0]  outstanding;
  logic [OUTSTANDING_W-1:0]  outstanding_eff;

  logic pipe_out_valid;
  logic pipe_out_is_write;
  logic mem_rsp;
  logic cop_rsp;
  logic addr_ok;
  logic mem_accept;
  logic cop_accept;

  logic unused_bits;
  assign unused_bits = ^{dmem_req.addr[31:SRAM_AW+2], dmem_req.addr[1:0],
                         dmem_req.size, dmem_req.cache_op.funct};

  // Responses are suppressed in a reset cycle so nothing in flight escapes.
  assign mem_rsp = pipe_out_valid & ~reset;
  assign cop_rsp = (state == RSP_CACHE_DONE) & ~reset;

  // A slot freed by this cycle's response is already usable, so addr_ok can
  // reassert in the same cycle as the data_ok that drops below DEPTH.
  assign outstanding_eff = outstanding - OUTSTANDING_W'(mem_rsp);

  always_comb begin
    addr_ok    = 1'b0;
    mem_accept = 1'b0;
    cop_accept = 1'b0;
    if (!reset && state == RSP_IDLE && dmem_req.req) begin
      if (dmem_req.cache_op.req) begin
        if (outstanding_eff == '0) begin
          addr_ok    = 1'b1;
          cop_accept = 1'b1;
        end
      end else if (outstanding_eff < DEPTH_L) begin
        addr_ok    = 1'b1;
        mem_accept = 1'b1;
      end
    end
  end

  assign sram_en   = mem_accept;
  assign sram_we   = (mem_accept && dmem_req.is_write) ? dmem_req.write_en : '0;
  assign sram_addr = dmem_req.addr[SRAM_AW+1:2];
  assign sram_wd   = dmem_req.data;

  always_comb begin
    dmem_resp         = '0;
    dmem_resp.addr_ok = addr_ok;
    dmem_resp.data_ok = mem_rsp | cop_rsp;
    if (mem_rsp && !pipe_out_is_write) begin
      dmem_resp.data = sram_rd;
    end
  end

  dbus_lat_pipe #(
    .LATENCY(MEM_LATENCY)
  ) u_lat_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (mem_accept),
    .in_is_write (dmem_req.is_write),
    .out_valid   (pipe_out_valid),
    .out_is_write(pipe_out_is_write)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({mem_accept, mem_rsp})
        2'b10:   outstanding <= outstanding + OUTSTANDING_W'(1);
        2'b01:   outstanding <= outstanding - OUTSTANDING_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RSP_IDLE;
      cop_cnt <= '0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (cop_accept) begin
            state   <= RSP_CACHE_BUSY;
            cop_cnt <= COP_LOAD;
          end
        end
        RSP_CACHE_BUSY: begin
          if (cop_cnt == '0) begin
            state <= RSP_CACHE_DONE;
          end else begin
            cop_cnt <= cop_cnt - COP_W'(1);
          end
        end
        RSP_CACHE_DONE: state <= RSP_IDLE;
        default:        state <= RSP_IDLE;
      endcase
    end
  end

`ifdef DBUS_RESP_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_cnt     <= '0;
      perf_stall_cnt   <= '0;
      perf_cacheop_cnt <= '0;
    end else begin
      if (mem_accept || cop_accept) begin
        perf_req_cnt <= sat_inc32(perf_req_cnt);
      end
      if (dmem_req.req && !addr_ok) begin
        perf_stall_cnt <= sat_inc32(perf_stall_cnt);
      end
      if (cop_accept) begin
        perf_cacheop_cnt <= sat_inc16(perf_cacheop_cnt);
      end
    end
  end
`endif

endmodule
